// File: rtl/spi_rom_line_fetcher.sv
// spi_rom_line_fetcher: reads one line of DATA_BYTES bytes from an SPI flash
// (mode 0, SCLK = clk/2, active-high chip select) into a byte-addressable
// line buffer that the pixel stage reads by index.
//
// Optional feature: define FAST_READ_EN to use the 0x0B fast-read command,
// which inserts 8 dummy SPI bits between the address and the data.
//
// Ports:
//   clk, reset     system clock; synchronous active-low reset
//   start, addr    fetch request (sampled only in IDLE) and start byte address
//   busy, done     busy from acceptance through DONE; done is a 1-cycle pulse
//   spi_cs         chip select (active high)
//   spi_sclk       SPI clock, idles low
//   spi_mosi       command/address bits, MSB first
//   spi_miso       ROM data in
//   rd_idx         line buffer read index
//   rd_data        line buffer byte at rd_idx (combinational)
module spi_rom_line_fetcher #(
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned ADDR_BITS = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] addr,
  output logic                 busy,
  output logic                 done,
  output logic                 spi_cs,
  output logic                 spi_sclk,
  output logic                 spi_mosi,
  input  logic                 spi_miso,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [7:0]           rd_data
);

  localparam int unsigned DATA_BYTES = 2 ** IDX_W;
  localparam int unsigned DATA_BITS  = 8 * DATA_BYTES;
  localparam int unsigned SR_W       = 8 + ADDR_BITS;
  localparam int unsigned CNT_W      = ((IDX_W + 3) > $clog2(ADDR_BITS)) ?
                                       (IDX_W + 3) : $clog2(ADDR_BITS);
`ifdef FAST_READ_EN
  localparam logic [7:0] CMD_BYTE = 8'h0B;
`else
  localparam logic [7:0] CMD_BYTE = 8'h03;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              cs_q, cs_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [6:0]        rx_q, rx_d;
  logic [7:0]        line_q [DATA_BYTES];
  logic [7:0]        line_d [DATA_BYTES];
  logic              last_bit;

  // Last bit of the current shifting state.
  always_comb begin
    last_bit = 1'b0;
    case (state_q)
      S_CMD:   last_bit = (cnt_q == CNT_W'(7));
      S_ADDR:  last_bit = (cnt_q == CNT_W'(ADDR_BITS - 1));
      S_DUMMY: last_bit = (cnt_q == CNT_W'(7));
      S_DATA:  last_bit = (cnt_q == CNT_W'(DATA_BITS - 1));
      default: last_bit = 1'b0;
    endcase
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    line_d  = line_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = S_CMD;
          cs_d    = 1'b1;
          busy_d  = 1'b1;
          sclk_d  = 1'b0;
          mosi_d  = CMD_BYTE[7];
          // Remaining bits queue behind the first; the trailing zero feeds
          // MOSI low once the address has gone out.
          sr_d    = {CMD_BYTE[6:0], addr, 1'b0};
          cnt_d   = '0;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        if (!sclk_q) begin
          // End of phase A: SCLK rises, ROM data is sampled.
          sclk_d = 1'b1;
          if (state_q == S_DATA) begin
            rx_d = {rx_q[5:0], spi_miso};
            if (cnt_q[2:0] == 3'd7) begin
              line_d[cnt_q[IDX_W+2:3]] = {rx_q, spi_miso};
            end
          end
        end else begin
          // End of phase B: SCLK falls, MOSI advances to the next bit.
          sclk_d = 1'b0;
          cnt_d  = cnt_q + CNT_W'(1);
          mosi_d = sr_q[SR_W-1];
          sr_d   = sr_q << 1;
          if (last_bit) begin
            cnt_d = '0;
            case (state_q)
              S_CMD:   state_d = S_ADDR;
`ifdef FAST_READ_EN
              S_ADDR:  state_d = S_DUMMY;
`else
              S_ADDR:  state_d = S_DATA;
`endif
              S_DUMMY: state_d = S_DATA;
              default: begin
                state_d = S_DONE;
                cs_d    = 1'b0;
                mosi_d  = 1'b0;
                done_d  = 1'b1;
              end
            endcase
          end
        end
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cs_q    <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sr_q    <= '0;
      cnt_q   <= '0;
      rx_q    <= '0;
      for (int i = 0; i < int'(DATA_BYTES); i++) line_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      line_q  <= line_d;
    end
  end

  assign spi_cs   = cs_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = line_q[rd_idx];

endmodule

// File: tb/tb_spi_rom_line_fetcher.sv
// Testbench for spi_rom_line_fetcher: behavioural SPI ROM, per-cycle protocol
// checks and a scoreboard of expected line contents popped on each done.
`timescale 1ns/1ps
module tb_spi_rom_line_fetcher;

  localparam int unsigned IDX_W     = 4;
  localparam int unsigned ADDR_BITS = 24;
  localparam int          NB        = 16;
`ifdef FAST_READ_EN
  localparam logic [7:0]  CMD    = 8'h0B;
  localparam int          HDR    = 40;
  localparam int          CS_CYC = 336;
`else
  localparam logic [7:0]  CMD    = 8'h03;
  localparam int          HDR    = 32;
  localparam int          CS_CYC = 320;
`endif

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic [ADDR_BITS-1:0] addr;
  logic                 busy, done, spi_cs, spi_sclk, spi_mosi, spi_miso;
  logic [IDX_W-1:0]     rd_idx;
  logic [7:0]           rd_data;

  spi_rom_line_fetcher #(.IDX_W(IDX_W), .ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr),
    .busy(busy), .done(done), .spi_cs(spi_cs), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .rd_idx(rd_idx),
    .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural ROM: shifts data out on SCLK falling, captures MOSI on rising.
  logic [7:0]  rom [NB];
  logic        cs_prev = 1'b0, sclk_prev = 1'b0;
  int          fall_cnt = 0, rise_cnt = 0, tail_ones = 0;
  logic [31:0] hdr_bits = '0;

  always @(spi_cs or spi_sclk) begin
    if (spi_cs && !cs_prev) begin
      fall_cnt  = 0;
      rise_cnt  = 0;
      tail_ones = 0;
      hdr_bits  = '0;
    end
    if (spi_cs && spi_sclk && !sclk_prev) begin
      if (rise_cnt < 32) hdr_bits = {hdr_bits[30:0], spi_mosi};
      else if (spi_mosi) tail_ones++;
      rise_cnt++;
    end
    if (!spi_sclk && sclk_prev) fall_cnt++;
    cs_prev   = spi_cs;
    sclk_prev = spi_sclk;
  end

  always_comb begin
    int n;
    n = fall_cnt - HDR;
    spi_miso = 1'b0;
    if (spi_cs && n >= 0 && n < 8 * NB) spi_miso = rom[n / 8][7 - (n % 8)];
  end

  logic [7:0] exp_q [$];

  task automatic check_zero_line(input string name);
    for (int i = 0; i < NB; i++) begin
      rd_idx = IDX_W'(i);
      #0.2;
      check($sformatf("%s zero[%0d]", name, i), 32'(rd_data), 32'h0);
    end
  endtask

  // One transfer, sampled #1 after each edge. Cycle c=1 is the first cycle
  // after the accepting edge.
  task automatic run_xfer(input string name, input logic [23:0] a, input bit pre,
                          input bit inject, input int abort_at, input bit chain,
                          input logic [23:0] next_a);
    int   cs_bad = 0, busy_bad = 0, done_bad = 0, sclk_bad = 0;
    int   done_cnt = 0, done_cyc = 0;
    int   end_cs;
    logic sclk_p = 1'b0;
    logic cs_exp, busy_exp, done_exp;
    if (!pre) begin
      start = 1'b1;
      addr  = a;
    end
    if (abort_at == 0) for (int i = 0; i < NB; i++) exp_q.push_back(rom[i]);
    end_cs = (abort_at > 0) ? abort_at : CS_CYC;
    for (int c = 1; c <= CS_CYC + 2; c++) begin
      @(posedge clk); #1;
      start    = 1'b0;
      cs_exp   = (c <= end_cs);
      busy_exp = (abort_at > 0) ? (c <= abort_at) : (c <= CS_CYC + 1);
      done_exp = (abort_at == 0) && (c == CS_CYC + 1);
      if (spi_cs !== cs_exp) cs_bad++;
      if (busy !== busy_exp) busy_bad++;
      if (done !== done_exp) done_bad++;
      if (!spi_cs || c == 1) begin
        if (spi_sclk !== 1'b0) sclk_bad++;
      end else if (spi_sclk === sclk_p) sclk_bad++;
      sclk_p = spi_sclk;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = c;
        if (exp_q.size() >= NB) begin
          for (int i = 0; i < NB; i++) begin
            rd_idx = IDX_W'(i);
            #0.2;
            check($sformatf("%s rd[%0d]", name, i), 32'(rd_data), 32'(exp_q.pop_front()));
          end
        end else begin
          check($sformatf("%s unexpected done", name), 32'(1), 32'(0));
        end
      end
      if (abort_at > 0 && c == abort_at) reset = 1'b0;
      if (abort_at > 0 && c == abort_at + 1) begin
        check_zero_line(name);
        reset = 1'b1;
      end
      if (inject && (c == 50 || c == CS_CYC + 1)) start = 1'b1;
      if (chain && c == CS_CYC + 2) begin
        start = 1'b1;
        addr  = next_a;
      end
    end
    check($sformatf("%s cs cycles", name), 32'(cs_bad), 32'(0));
    check($sformatf("%s busy cycles", name), 32'(busy_bad), 32'(0));
    check($sformatf("%s done cycles", name), 32'(done_bad), 32'(0));
    check($sformatf("%s sclk toggle", name), 32'(sclk_bad), 32'(0));
    if (abort_at == 0) begin
      check($sformatf("%s done count", name), 32'(done_cnt), 32'(1));
      check($sformatf("%s done cycle", name), 32'(done_cyc), 32'(CS_CYC + 1));
      check($sformatf("%s mosi hdr", name), hdr_bits, {CMD, a});
      check($sformatf("%s mosi tail", name), 32'(tail_ones), 32'(0));
      check($sformatf("%s sclk rises", name), 32'(rise_cnt), 32'(CS_CYC / 2));
    end else begin
      check($sformatf("%s done count", name), 32'(done_cnt), 32'(0));
    end
  endtask

  task automatic rom_random();
    for (int i = 0; i < NB; i++) rom[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    addr   = '0;
    rd_idx = '0;
    for (int i = 0; i < NB; i++) rom[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst cs", 32'(spi_cs), 32'(0));
    check("rst sclk", 32'(spi_sclk), 32'(0));
    check("rst mosi", 32'(spi_mosi), 32'(0));
    check("rst busy", 32'(busy), 32'(0));
    check("rst done", 32'(done), 32'(0));
    check_zero_line("rst");
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NB; i++) rom[i] = 8'(i);
    run_xfer("seq", 24'h000140, 1'b0, 1'b0, 0, 1'b0, 24'h0);

    for (int i = 0; i < NB; i++) rom[i] = (i % 2 == 0) ? 8'hA5 : 8'h5A;
    run_xfer("alt", 24'h123456, 1'b0, 1'b0, 0, 1'b0, 24'h0);

    rom_random();
    run_xfer("inj", 24'hABCDEF, 1'b0, 1'b1, 0, 1'b1, 24'h000010);
    rom_random();
    run_xfer("chain", 24'h000010, 1'b1, 1'b0, 0, 1'b0, 24'h0);

    rom_random();
    run_xfer("abort", 24'h00FF00, 1'b0, 1'b0, 200, 1'b0, 24'h0);
    rom_random();
    run_xfer("post", 24'h000020, 1'b0, 1'b0, 0, 1'b0, 24'h0);

    rom_random();
    run_xfer("a0", 24'h000000, 1'b0, 1'b0, 0, 1'b0, 24'h0);

    check("queue empty", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
